// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions used by the transmitter and the
//                receiver: line-state encoding, byte type and default bit
//                timing constants.
//  Contents    : uart_byte_t  - byte as sent on the wire, index 0 goes first
//                uart_state_t - IDLE / START_BIT / DATA_BITS / STOP_BIT
//                DEF_FULL_BIT - default clock cycles per serial bit
//                DEF_HALF_BIT - half a bit period (receiver mid-bit sampling)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEF_FULL_BIT = 21812;
    localparam int DEF_HALF_BIT = DEF_FULL_BIT / 2;

    // Ascending range so that index 0 is both the leftmost literal bit and
    // the first bit on the line.
    typedef logic [0:7] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter_if
//  Description : Byte-push handshake and serial-side status of the UART
//                transmitter.
//  Signals     : i_data  - byte to send (index 0 first)
//                i_valid - i_data valid this cycle
//                o_ready - transmitter can take a byte this cycle
//                o_tx    - serial line, idle high
//                o_busy  - frame in flight or bytes still queued
//  Modports    : master - byte producer / line observer
//                slave  - the transmitter
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if ();
    import uart_pkg::*;

    uart_byte_t i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_tx,
        input  o_busy
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_tx,
        output o_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous holding FIFO for bytes waiting to be sent.
//                Head data is presented combinationally; a push into a full
//                FIFO or a pop from an empty one is ignored.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset, empties the FIFO
//                push    - write wr_data at the tail
//                pop     - drop the head entry
//                wr_data - byte to write
//                rd_data - head entry
//                full    - occupancy equals DEPTH
//                empty   - occupancy is zero
//                count   - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      push,
    input  wire                      pop,
    input  uart_byte_t               wr_data,
    output uart_byte_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]    C_FULL = (C_AW + 1)'(DEPTH);

    uart_byte_t        r_mem [DEPTH];
    logic [C_AW-1:0]   r_wr_ptr;
    logic [C_AW-1:0]   r_rd_ptr;
    logic [C_AW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full    = (r_count == C_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_do_push = push && !full && !rst;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (C_AW + 1)'(1);
                2'b01:   r_count <= r_count - (C_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter
//  Description : 8N1 UART transmitter with a small holding FIFO. Each frame
//                is one low start bit, eight data bits (index 0 first) and
//                one high stop bit, each FULL_BIT clock cycles long. Frames
//                are separated by at least one idle cycle.
//  Ports       : clk     - clock
//                i_reset - synchronous active-high reset; aborts any frame
//                bus     - slave side of uart_transmitter_if
//                          (i_data, i_valid, o_ready, o_tx, o_busy)
//  Parameters  : FULL_BIT   - cycles per serial bit, 2..65535
//                FIFO_DEPTH - holding FIFO entries, power of two, 2..16
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FULL_BIT   = DEF_FULL_BIT,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                 clk,
    input  wire                 i_reset,
    uart_transmitter_if.slave   bus
);

    localparam int          C_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] C_LAST_CYC = 16'(FULL_BIT - 1);

    uart_state_t        r_state;
    logic [15:0]        r_cyc_cnt;
    logic [3:0]         r_bit_cnt;
    uart_byte_t         r_shift_reg;
    logic               r_tx;
    logic               r_busy;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_bit_end;
    logic [C_CNT_W-1:0] w_count;
    uart_byte_t         w_head;

    // Ready depends on registered occupancy only, so a pop in the same cycle
    // does not open a slot until the following cycle.
    assign bus.o_ready = !w_full;
    assign bus.o_tx    = r_tx;
    assign bus.o_busy  = r_busy;

    assign w_push    = bus.i_valid && !w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_bit_end = (r_cyc_cnt == C_LAST_CYC);

    uart_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (i_reset),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (bus.i_data),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // o_tx and o_busy are registered from the current state, so the line
    // follows the state by one cycle: a byte popped at edge N+1 starts
    // driving the start bit at edge N+2.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cyc_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift_reg <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_busy    <= (r_state != IDLE) || (w_count != '0);
            r_cyc_cnt <= w_bit_end ? '0 : r_cyc_cnt + 16'd1;

            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_cyc_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (!w_empty) begin
                        r_shift_reg <= w_head;
                        r_state     <= START_BIT;
                    end
                end

                START_BIT: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_state <= DATA_BITS;
                    end
                end

                DATA_BITS: begin
                    r_tx <= r_shift_reg[0];
                    if (w_bit_end) begin
                        r_shift_reg <= {r_shift_reg[1:7], 1'b0};
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= STOP_BIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end

                STOP_BIT: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmitter
//  Description : Self-checking bench for uart_transmitter with FULL_BIT=4 and
//                FIFO_DEPTH=4. Directed frame vectors, a loopback receiver
//                model, FIFO back-pressure and reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int FB    = 4;
    localparam int HB    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        uart_byte_t  data;
        logic [0:9]  line;   // expected line level per bit period, start first
    } vec_t;

    logic        clk     = 1'b0;
    logic        i_reset = 1'b1;
    int unsigned cyc     = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    uart_byte_t  rx_q[$];
    int          rx_err = 0;
    bit          rx_en  = 1'b1;
    uart_byte_t  rx_b;

    vec_t        vecs[5];
    uart_byte_t  bvals[5];
    int unsigned acc_edge[5];
    int unsigned t_a;

    uart_transmitter_if bus ();

    uart_transmitter #(
        .FULL_BIT   (FB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input uart_byte_t d);
        @(negedge clk);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic check_rx(input int idx, input uart_byte_t exp, input string nm);
        if (idx < rx_q.size()) check(nm, rx_q[idx], exp);
        else check(nm, 32'hdead_beef, exp);
    endtask

    // Push one byte into an idle transmitter and check the full line waveform.
    task automatic send_and_check(input uart_byte_t d, input logic [0:9] exp, input string nm);
        @(negedge clk);
        check({nm, " ready"}, bus.o_ready, 1'b1);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        @(posedge clk);                                  // edge N
        #1;
        bus.i_valid = 1'b0;
        step(1);                                         // after N+1
        check({nm, " tx still idle"}, bus.o_tx, 1'b1);
        check({nm, " busy"}, bus.o_busy, 1'b1);
        step(2);                                         // after N+3: mid start bit
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step(FB);
            check($sformatf("%s bit%0d", nm, k), bus.o_tx, exp[k]);
        end
        step(2);                                         // after N+41
        check({nm, " busy N+41"}, bus.o_busy, 1'b1);
        step(1);                                         // after N+42
        check({nm, " busy N+42"}, bus.o_busy, 1'b0);
    endtask

    // Loopback receiver: detect start, sample mid-bit.
    initial begin : rx_model
        forever begin
            @(negedge clk);
            if (bus.o_tx === 1'b0) begin
                repeat (HB - 1) @(negedge clk);
                if (bus.o_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (FB) @(negedge clk);
                        rx_b[i] = bus.o_tx;
                    end
                    repeat (FB) @(negedge clk);
                    if (rx_en) begin
                        if (bus.o_tx === 1'b1) rx_q.push_back(rx_b);
                        else rx_err++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "time limit");
    end

    initial begin : main
        vecs[0] = '{8'b1010_0011, 10'b0_1010_0011_1};
        vecs[1] = '{8'b0000_0000, 10'b0_0000_0000_1};
        vecs[2] = '{8'b1111_1111, 10'b0_1111_1111_1};
        vecs[3] = '{8'b0101_0101, 10'b0_0101_0101_1};
        vecs[4] = '{8'b1100_0001, 10'b0_1100_0001_1};
        bvals[0] = 8'h11;
        bvals[1] = 8'h22;
        bvals[2] = 8'h33;
        bvals[3] = 8'h44;
        bvals[4] = 8'h5A;

        bus.i_data  = '0;
        bus.i_valid = 1'b0;

        // Reset state, then 50 idle cycles
        step(1);
        check("reset o_tx", bus.o_tx, 1'b1);
        check("reset o_busy", bus.o_busy, 1'b0);
        check("reset o_ready", bus.o_ready, 1'b1);
        @(negedge clk);
        i_reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            check("idle o_tx", bus.o_tx, 1'b1);
            check("idle o_busy", bus.o_busy, 1'b0);
            check("idle o_ready", bus.o_ready, 1'b1);
        end

        // Table-driven frame vectors
        for (int v = 0; v < 5; v++) begin
            send_and_check(vecs[v].data, vecs[v].line, $sformatf("vec%0d", v));
            step(1);
        end
        step(4);
        check("vec rx count", rx_q.size(), 5);
        for (int v = 0; v < 5; v++) check_rx(v, vecs[v].data, $sformatf("vec%0d rx", v));

        // Back-pressure: one frame in flight, then five bytes back-to-back
        rx_q.delete();
        push_byte(8'h3C);
        t_a = cyc;
        for (int k = 0; k < 5; k++) begin
            bit got;
            logic rdy;
            got = 1'b0;
            acc_edge[k] = 0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge clk);
                bus.i_data  = bvals[k];
                bus.i_valid = 1'b1;
                rdy = bus.o_ready;
                @(posedge clk);
                #1;
                if (rdy) begin
                    got = 1'b1;
                    acc_edge[k] = cyc - t_a;
                end
            end
            bus.i_valid = 1'b0;
        end
        check("b2b byte1 accept edge", acc_edge[0], 1);
        check("b2b byte2 accept edge", acc_edge[1], 2);
        check("b2b byte3 accept edge", acc_edge[2], 3);
        check("b2b byte4 accept edge", acc_edge[3], 4);
        check("b2b byte5 accept edge", acc_edge[4], 43);
        check("b2b full after byte5", bus.o_ready, 1'b0);
        for (int w = 0; w < 400 && bus.o_busy !== 1'b0; w++) step(1);
        check("b2b drain busy", bus.o_busy, 1'b0);
        check("b2b drain edge", cyc - t_a, 247);
        step(5);
        check("b2b rx count", rx_q.size(), 6);
        check_rx(0, 8'h3C, "b2b rx0");
        for (int k = 0; k < 5; k++) check_rx(k + 1, bvals[k], $sformatf("b2b rx%0d", k + 1));

        // Reset during data bit 3 with a second byte queued
        rx_en = 1'b0;
        push_byte(8'b1110_0000);
        push_byte(8'h81);
        step(17);
        check("abort bit3 level", bus.o_tx, 1'b0);
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("abort o_tx", bus.o_tx, 1'b1);
        check("abort o_busy", bus.o_busy, 1'b0);
        check("abort o_ready", bus.o_ready, 1'b1);
        step(45);
        check("abort stays idle o_tx", bus.o_tx, 1'b1);
        check("abort stays idle o_busy", bus.o_busy, 1'b0);

        // Push during reset is dropped; first byte after reset goes through
        rx_q.delete();
        rx_en = 1'b1;
        @(negedge clk);
        i_reset     = 1'b1;
        bus.i_data  = 8'hFF;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_reset     = 1'b0;
        bus.i_valid = 1'b0;
        check("reset push o_busy", bus.o_busy, 1'b0);
        send_and_check(8'h55, 10'b0_0101_0101_1, "post-reset 0x55");
        step(3);
        check("post-reset rx count", rx_q.size(), 1);
        check_rx(0, 8'h55, "post-reset rx");
        check("rx framing errors", rx_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter: FULL_BIT, 21812, clock cycles per serial bit (start, data and stop bits alike); legal range 2..65535.
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, entries in the transmit holding buffer; power of two, 2..16.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: i_reset  input  1  synchronous, active-high reset, sampled at posedge clk.
REQ-005 SHALL have port: i_data  input  [0:7]  byte to transmit; i_data[0] is sent first.
REQ-006 SHALL have port: i_valid  input  1  i_data is valid this cycle.
REQ-007 SHALL have port: o_ready  output  1  buffer can accept a byte this cycle (not full).
REQ-008 SHALL have port: o_tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port: o_busy  output  1  high while a frame is in flight or the buffer is non-empty.

Function
REQ-010 A byte SHALL be accepted exactly when i_valid and o_ready are both high at a posedge; it is written to the buffer tail.
REQ-011 o_ready SHALL be a function of registered buffer occupancy only: low when occupancy equals FIFO_DEPTH, even if a pop occurs in the same cycle.
REQ-012 Simultaneous push and pop on a non-full buffer SHALL both take effect; occupancy is unchanged.
REQ-013 The FSM SHALL have states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-014 IDLE: if the buffer is non-empty, pop the head into a shift register, clear the cycle and bit counters, and go to START_BIT; otherwise stay in IDLE.
REQ-015 o_tx SHALL be registered alongside the state: 1 in IDLE, 0 in START_BIT, the current data bit in DATA_BITS, and 1 in STOP_BIT.
REQ-016 Each of START_BIT, each data bit and STOP_BIT SHALL last exactly FULL_BIT cycles; the 16-bit cycle counter counts 0..FULL_BIT-1 and wraps to 0 at each bit boundary.
REQ-017 DATA_BITS SHALL send bits in index order 0..7; the 4-bit bit counter advances on each bit boundary, and after bit 7 the FSM goes to STOP_BIT.
REQ-018 STOP_BIT end SHALL go to IDLE; frames are separated by at least one IDLE cycle (minimum frame period 10*FULL_BIT+1 cycles).
REQ-019 Latency: a byte pushed into an empty buffer at edge N while in IDLE SHALL drive o_tx low from edge N+2.
REQ-020 The byte under transmission SHALL be held in the shift register; pushes during a frame SHALL NOT alter the frame in flight.
REQ-021 o_busy SHALL be high iff state != IDLE or occupancy != 0.

Reset
REQ-022 While i_reset is high at a posedge: state=IDLE, o_tx=1, all counters=0, buffer emptied (o_ready=1, o_busy=0), and any push that cycle is discarded.
REQ-023 Reset mid-frame SHALL abort the frame; o_tx returns high on the same edge, with no partial stop bit.
REQ-024 The first byte after reset deasserts SHALL be accepted on the next cycle.

Structure
REQ-025 The state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT) and default FULL_BIT/HALF_BIT constants SHALL live in a shared package uart_pkg, also used by the receiver.
REQ-026 The holding buffer SHALL be one sub-module, uart_tx_fifo (synchronous FIFO: push, pop, full, empty, count).
REQ-027 Target size is 120-400 lines of RTL in total; no other sub-modules.

Verification (FULL_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-028 Reset, then idle 50 cycles -> o_tx=1, o_busy=0, o_ready=1 throughout.
REQ-029 Push 8'b1010_0011 ([0]=1) at edge N -> o_tx low at N+2 for 4 cycles; then bits 1,0,1,0,0,0,1,1 for 4 cycles each; then high for 4 cycles; o_busy falls at N+42.
REQ-030 Push 5 bytes back-to-back -> bytes 1-4 accepted, o_ready low for byte 5 until the first pop; loopback receiver (FULL_BIT=4, HALF_BIT=2) reports the accepted bytes in order.
REQ-031 Assert i_reset during data bit 3 -> o_tx=1 on the next edge, buffer empty; a later push of 0x55 is transmitted intact.
REQ-032 At full occupancy, assert i_valid on the same cycle the FSM pops -> push rejected (o_ready was 0); occupancy drops to 3.
